// File: rtl/alu_arbiter_ctrl_pkg.sv
// rtl/alu_arbiter_ctrl_pkg.sv - shared widths, opcodes and FSM states for the ALU arbiter controller
package alu_arbiter_ctrl_pkg;

    localparam int ALU_W = 32;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
    localparam logic [OP_W-1:0] OP_SLT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Opcodes 101..111 have no ALU function and are answered with an error.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_OR, OP_AND, OP_SUB, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// rtl/alu_arbiter_ctrl_if.sv - requester and ALU side signal bundle of the shared ALU controller
interface alu_arbiter_ctrl_if #(parameter int NREQ = 4);
    import alu_arbiter_ctrl_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ALU_W-1:0] req_x;
    logic [NREQ*ALU_W-1:0] req_y;
    logic [NREQ*OP_W-1:0]  req_op;

    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [ALU_W-1:0]      rsp_f;
    logic                  rsp_ovf;
    logic                  rsp_cout;
    logic                  rsp_zero;
    logic                  rsp_err;

    logic [ALU_W-1:0]      alu_x;
    logic [ALU_W-1:0]      alu_y;
    logic [OP_W-1:0]       alu_opcode;
    logic [ALU_W-1:0]      alu_f;
    logic                  alu_overflow;
    logic                  alu_cout;
    logic                  alu_zero;

    modport master (
        output req_valid, req_x, req_y, req_op, rsp_ready,
        output alu_f, alu_overflow, alu_cout, alu_zero,
        input  req_ready, rsp_valid, rsp_f, rsp_ovf, rsp_cout, rsp_zero, rsp_err,
        input  alu_x, alu_y, alu_opcode
    );

    modport slave (
        input  req_valid, req_x, req_y, req_op, rsp_ready,
        input  alu_f, alu_overflow, alu_cout, alu_zero,
        output req_ready, rsp_valid, rsp_f, rsp_ovf, rsp_cout, rsp_zero, rsp_err,
        output alu_x, alu_y, alu_opcode
    );
endinterface

// File: rtl/alu_arbiter_ctrl_rr_arbiter.sv
// rtl/alu_arbiter_ctrl_rr_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    // Pick the requester closest to ptr going upward with wrap; distance k is scanned in order.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((i + NREQ - int'(ptr)) % NREQ) == k)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// rtl/alu_arbiter_ctrl.sv - shares one multi-cycle ALU among NREQ requesters with round-robin grant
module alu_arbiter_ctrl
    import alu_arbiter_ctrl_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_ctrl_if.slave bus,
    output logic             busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  owner;

    logic [ALU_W-1:0] alu_x_q;
    logic [ALU_W-1:0] alu_y_q;
    logic [OP_W-1:0]  alu_op_q;

    logic [NREQ-1:0]  rsp_valid_q;
    logic [ALU_W-1:0] rsp_f_q;
    logic             rsp_ovf_q;
    logic             rsp_cout_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    logic [NREQ-1:0]  grant;
    logic [ALU_W-1:0] g_x;
    logic [ALU_W-1:0] g_y;
    logic [OP_W-1:0]  g_op;
    logic [PW-1:0]    next_ptr;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Select the granted requester's operands and the pointer slot just after it.
    always_comb begin
        g_x      = '0;
        g_y      = '0;
        g_op     = '0;
        next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_x      = bus.req_x[i*ALU_W +: ALU_W];
                g_y      = bus.req_y[i*ALU_W +: ALU_W];
                g_op     = bus.req_op[i*OP_W +: OP_W];
                next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Controller FSM: accept, let the ALU settle, capture, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            owner       <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= '0;
            rsp_f_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        rr_ptr <= next_ptr;
                        owner  <= grant;
                        if (op_legal(g_op)) begin
                            alu_x_q  <= g_x;
                            alu_y_q  <= g_y;
                            alu_op_q <= g_op;
                            cnt      <= CW'(SETTLE_CYCLES - 1);
                            state    <= (SETTLE_CYCLES == 1) ? ST_CAPT : ST_WAIT;
                        end else begin
                            // Illegal opcode never touches the ALU; the error reply is raised next edge.
                            rsp_f_q    <= '0;
                            rsp_ovf_q  <= 1'b0;
                            rsp_cout_q <= 1'b0;
                            rsp_zero_q <= 1'b0;
                            rsp_err_q  <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_CAPT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_CAPT: begin
                    rsp_f_q     <= bus.alu_f;
                    rsp_ovf_q   <= bus.alu_overflow;
                    rsp_cout_q  <= bus.alu_cout;
                    rsp_zero_q  <= bus.alu_zero;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= owner;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    // Entered without valid only on the illegal-op path; raise it here.
                    if (rsp_valid_q == '0) begin
                        rsp_valid_q <= owner;
                    end else if (|(bus.rsp_ready & owner)) begin
                        rsp_valid_q <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE) ? grant : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_f      = rsp_f_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_x      = alu_x_q;
    assign bus.alu_y      = alu_y_q;
    assign bus.alu_opcode = alu_op_q;
    assign busy           = (state != ST_IDLE);

endmodule
